// File: rtl/ysyx_24070014_mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM encoding, the latency
// counter width and the default memory map constants.
package ysyx_24070014_mem_responder_pkg;

  // Responder FSM: accept a request, count down the access latency, present
  // the response until it is taken.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W = 4;

  localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h8000_0000;
  localparam int          DEFAULT_DEPTH_LOG2 = 12;

endpackage

// File: rtl/ysyx_24070014_sram_array.sv
// Single-port synchronous word array with per-byte write enable and a
// registered read port. Contents are never reset. The read register only
// updates on an enabled read, so it holds its value while the port is idle.
module ysyx_24070014_sram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [DEPTH_LOG2-1:0]   idx_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wmask_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Byte-masked write or registered read, one access per enabled cycle.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (wmask_i[b]) begin
            mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_24070014_mem_responder.sv
// Memory-side responder: one outstanding request, fixed access latency,
// range-checked word array access.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where
// resp_valid and resp_ready are both 1. req_ready is high only in IDLE and
// resp_valid only in RESP, so the two never overlap and a new request can
// not be accepted in the cycle a response retires. While resp_valid is high,
// resp_rdata and resp_err are held stable.
//
// Build option: define YSYX_24070014_MEM_MISALIGN_CHECK_EN to fault accesses
// whose addr[1:0] is nonzero; otherwise the low address bits are ignored.
// The FSM state is observable as state_q for checkers.
module ysyx_24070014_mem_responder
  import ysyx_24070014_mem_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
  parameter int                    LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_wen,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int MW = DATA_WIDTH / 8;

  // Bounds held one bit wider than the address so BASE + span cannot wrap.
  localparam logic [ADDR_WIDTH:0] LO_EXT = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] SPAN   =
    {{ADDR_WIDTH{1'b0}}, 1'b1} << (DEPTH_LOG2 + 2);
  localparam logic [ADDR_WIDTH:0] HI_EXT = LO_EXT + SPAN;

  mem_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MW-1:0]         wmask_q, wmask_d;
  logic                  rd_ok_q, rd_ok_d;
  logic                  err_q, err_d;

  logic                  commit;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic                  c_wen;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [MW-1:0]         c_wmask;
  logic [ADDR_WIDTH:0]   c_addr_ext;
  logic [ADDR_WIDTH-1:0] c_off;
  logic                  c_err;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic                  sram_en;
  logic [DATA_WIDTH-1:0] sram_rdata;
  logic                  unused_off_bits;

  // Next-state, request latching and commit decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wen_d   = req_wen;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          if (LATENCY == 1) begin
            commit  = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands of the committing access: live inputs for a single-cycle
  // commit straight out of IDLE, latched copies otherwise.
  always_comb begin
    if (state_q == ST_IDLE) begin
      c_addr  = req_addr;
      c_wen   = req_wen;
      c_wdata = req_wdata;
      c_wmask = req_wmask;
    end else begin
      c_addr  = addr_q;
      c_wen   = wen_q;
      c_wdata = wdata_q;
      c_wmask = wmask_q;
    end
  end

  // Range check, word index and misalignment fault.
  always_comb begin
    c_addr_ext = {1'b0, c_addr};
    c_off      = c_addr - BASE_ADDR;
    c_idx      = c_off[DEPTH_LOG2+1:2];
    c_err      = (c_addr_ext < LO_EXT) || (c_addr_ext >= HI_EXT);
`ifdef YSYX_24070014_MEM_MISALIGN_CHECK_EN
    if (c_off[1:0] != 2'b00) begin
      c_err = 1'b1;
    end
`endif
  end

  assign unused_off_bits = ^{c_off[ADDR_WIDTH-1:DEPTH_LOG2+2], c_off[1:0]};

  // Array access only on a good commit; reset drops a pending write.
  assign sram_en = commit && reset && !c_err;

  // Response flags: set on commit, cleared when the response retires.
  always_comb begin
    rd_ok_d = rd_ok_q;
    err_d   = err_q;
    if (commit) begin
      rd_ok_d = !c_wen && !c_err;
      err_d   = c_err;
    end else if (state_q == ST_RESP && resp_ready) begin
      rd_ok_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  // State, counter, latched request and response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rd_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rd_ok_q <= rd_ok_d;
      err_q   <= err_d;
    end
  end

  ysyx_24070014_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sram (
    .clk     (clk),
    .en_i    (sram_en),
    .we_i    (c_wen),
    .idx_i   (c_idx),
    .wdata_i (c_wdata),
    .wmask_i (c_wmask),
    .rdata_o (sram_rdata)
  );

  // The array read register holds its word while idle, so it doubles as the
  // response data register; it is gated to zero for writes and faults.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = err_q;
  assign resp_rdata = rd_ok_q ? sram_rdata : '0;

endmodule

// File: tb/tb_ysyx_24070014_mem_responder.sv
// Bench for ysyx_24070014_mem_responder: directed scenarios plus randomized
// traffic checked against a word-array reference model.
module tb_ysyx_24070014_mem_responder;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          MW    = DW / 8;
  localparam int          DL2   = 12;
  localparam int          WORDS = 4096;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          req_wen = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic [MW-1:0] req_wmask = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  always #5 clk = ~clk;

  ysyx_24070014_mem_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH_LOG2 (DL2),
    .BASE_ADDR  (BASE),
    .LATENCY    (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wen    (req_wen),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW:0]   exp_q[$];     // {err, rdata}
  bit            chk_q[$];     // whether rdata is defined
  logic [DW-1:0] mem_m [WORDS];
  bit            known_m [WORDS];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: applies one access to the model and returns {err, rdata}.
  function automatic logic [DW:0] model_access(input logic [31:0] addr,
      input bit wen, input logic [31:0] wdata, input logic [3:0] wmask,
      output bit rd_defined);
    longint a = longint'(addr);
    longint b = longint'(BASE);
    bit     err = (a < b) || (a >= b + 4 * WORDS);
    int     idx;
`ifdef YSYX_24070014_MEM_MISALIGN_CHECK_EN
    if (addr % 4 != 0) err = 1;
`endif
    rd_defined = 1;
    if (err) return {1'b1, 32'h0};
    idx = int'((a - b) / 4);
    if (wen) begin
      for (int k = 0; k < MW; k++)
        if (wmask[k]) mem_m[idx][k*8 +: 8] = wdata[k*8 +: 8];
      if (wmask == 4'hF) known_m[idx] = 1;
      return {1'b0, 32'h0};
    end
    rd_defined = known_m[idx];
    return {1'b0, mem_m[idx]};
  endfunction

  // ---------------- driver ----------------
  // Called in the "just after a rising edge" phase; returns in that phase.
  task automatic do_txn(input logic [31:0] addr, input bit wen,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input int hold);
    logic [DW:0]   exp;
    bit            dfn;
    int            lat;
    logic [DW-1:0] r0;
    logic          e0;
    exp = model_access(addr, wen, wdata, wmask, dfn);
    exp_q.push_back(exp);
    chk_q.push_back(dfn);
    check_eq("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1; req_addr = addr; req_wen = wen;
    req_wdata = wdata; req_wmask = wmask;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", lat, LAT);
    exp = exp_q.pop_front();
    dfn = chk_q.pop_front();
    check_eq("resp_err", {31'b0, resp_err}, {31'b0, exp[DW]});
    if (dfn) check_eq("resp_rdata", resp_rdata, exp[DW-1:0]);
    r0 = resp_rdata;
    e0 = resp_err;
    for (int h = 0; h < hold; h++) begin
      // Requests offered while a response is pending must be ignored.
      req_valid = 1;
      req_addr  = BASE + 32'($urandom_range(0, WORDS - 1) * 4);
      req_wen   = 1'($urandom_range(0, 1));
      req_wdata = $urandom;
      req_wmask = 4'hF;
      @(posedge clk); #1;
      check_eq("hold_valid", {31'b0, resp_valid}, 32'd1);
      check_eq("hold_req_ready", {31'b0, req_ready}, 32'd0);
      check_eq("hold_rdata", resp_rdata, r0);
      check_eq("hold_err", {31'b0, resp_err}, {31'b0, e0});
    end
    req_valid  = 0;
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    check_eq("retire_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("retire_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] pool [16];

  initial begin
    for (int i = 0; i < WORDS; i++) known_m[i] = 0;

    // Reset behaviour.
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'd0);
    reset = 1;
    @(posedge clk); #1;
    check_eq("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Full-word write then read back.
    do_txn(32'h8000_0010, 1, 32'hDEAD_BEEF, 4'hF, 0);
    do_txn(32'h8000_0010, 0, 32'h0, 4'h0, 0);

    // Byte-masked write over an existing word.
    do_txn(32'h8000_0020, 1, 32'h1122_3344, 4'hF, 0);
    do_txn(32'h8000_0020, 1, 32'h0000_00AA, 4'b0001, 0);
    do_txn(32'h8000_0020, 0, 32'h0, 4'h0, 0);
    check_eq("masked_model", mem_m[8], 32'h1122_33AA);

    // Range edges.
    do_txn(32'h7FFF_FFFC, 0, 32'h0, 4'h0, 0);
    do_txn(32'h8000_4000, 0, 32'h0, 4'h0, 0);
    do_txn(32'h8000_4000, 1, 32'h1234_5678, 4'hF, 0);
    do_txn(32'h8000_3FFC, 1, 32'hA5A5_5A5A, 4'hF, 0);
    do_txn(32'h8000_3FFC, 0, 32'h0, 4'h0, 0);
    do_txn(32'hFFFF_FFFC, 0, 32'h0, 4'h0, 0);

    // Empty mask is a legal no-op.
    do_txn(32'h8000_0010, 1, 32'h0BAD_0BAD, 4'h0, 0);
    do_txn(32'h8000_0010, 0, 32'h0, 4'h0, 0);

    // Back-pressure on a read response.
    do_txn(32'h8000_0020, 0, 32'h0, 4'h0, 5);

    // Reset during the wait of a write: the write must be dropped.
    do_txn(32'h8000_0030, 1, 32'h1357_9BDF, 4'hF, 0);
    req_valid = 1; req_addr = 32'h8000_0030; req_wen = 1;
    req_wdata = 32'h0000_0055; req_wmask = 4'hF;
    @(posedge clk); #1;
    req_valid = 0;
    check_eq("wait_no_resp", {31'b0, resp_valid}, 32'd0);
    reset = 0;
    @(posedge clk); #1;
    check_eq("rst_wait_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("rst_wait_rdata", resp_rdata, 32'd0);
    reset = 1;
    @(posedge clk); #1;
    check_eq("rst_wait_req_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_wait_valid2", {31'b0, resp_valid}, 32'd0);
    do_txn(32'h8000_0030, 0, 32'h0, 4'h0, 0);

    // Sub-word address handling.
    do_txn(32'h8000_0000, 1, 32'hCAFE_F00D, 4'hF, 0);
    do_txn(32'h8000_0002, 0, 32'h0, 4'h0, 0);
    do_txn(32'h8000_0001, 1, 32'hFFFF_FFFF, 4'hF, 0);
    do_txn(32'h8000_0000, 0, 32'h0, 4'h0, 0);

    // Randomized traffic over a small pool of words plus faulting addresses.
    pool[0] = BASE;
    pool[1] = BASE + 32'h3FFC;
    for (int i = 2; i < 16; i++) pool[i] = BASE + 32'($urandom_range(0, WORDS - 1) * 4);
    for (int i = 0; i < 16; i++) do_txn(pool[i], 1, $urandom, 4'hF, 0);
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      int          sel = $urandom_range(0, 99);
      if (sel < 85) begin
        a = pool[$urandom_range(0, 15)];
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      end else begin
        case ($urandom_range(0, 3))
          0:       a = BASE - 32'($urandom_range(1, 8));
          1:       a = BASE + 32'h4000 + 32'($urandom_range(0, 16));
          2:       a = 32'($urandom_range(0, 32'h7FFF_FFFF));
          default: a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        endcase
      end
      do_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24070014_mem_responder.md
Name: ysyx_24070014_mem_responder

Overview:
- Memory-side responder (target) for the core's data/instruction memory interface. Replaces the direct combinational memory hookup with a valid/ready request/response protocol.
- Stores a word array with byte-masked writes, models a fixed access latency and flags out-of-range accesses.
- Sits between the core's memory port and simulation/SoC glue.

Parameters:
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, data width; byte mask is DATA_WIDTH/8 bits
- DEPTH_LOG2, 12, log2 of word count (4096 words = 16 KiB)
- BASE_ADDR, 32'h80000000, byte address of word 0
- LATENCY, 2, cycles from request accept to resp_valid; legal range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset (0 = in reset)
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_addr  in  ADDR_WIDTH  byte address
- req_wen  in  1  1 = write, 0 = read
- req_wdata  in  DATA_WIDTH  write data
- req_wmask  in  DATA_WIDTH/8  per-byte write enable
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts response
- resp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- resp_err  out  1  access fault

Behaviour:
- FSM states:
  - IDLE: req_ready=1. On req_valid: latch addr/wen/wdata/wmask, load cnt=LATENCY-1, go to WAIT, or directly to RESP when LATENCY=1.
  - WAIT: cnt decrements each cycle. When cnt reaches 0, commit and go to RESP.
  - RESP: resp_valid=1. On resp_ready, go to IDLE.
- req_ready=1 only in IDLE, so at most one outstanding request. No accept in the same cycle a response retires.
- Latency: request accepted at edge N gives resp_valid high from edge N+LATENCY; held with stable rdata/err until resp_ready.
- Commit (edge entering RESP):
  - Index = (addr-BASE_ADDR)>>2, truncated to DEPTH_LOG2 bits.
  - Write updates only bytes with wmask bit set; rdata=0.
  - Read captures the array word into resp_rdata; later writes do not disturb a pending response.
- Range check: addr < BASE_ADDR or addr >= BASE_ADDR + 4*2^DEPTH_LOG2 gives resp_err=1, rdata=0, no array change. Compute the range check in ADDR_WIDTH+1 bits so the upper bound cannot wrap.
- wmask=0 on a write: no bytes change, resp_err=0 (legal no-op).
- Top word (index 2^DEPTH_LOG2-1) is valid. The next byte address past it is an error.
- Reset (reset=0) in any state:
  - state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, cnt=0; req_ready=1 once reset deasserts.
  - An uncommitted pending write is dropped.
  - Array contents are not reset.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- YSYX_24070014_MEM_MISALIGN_CHECK_EN defined: addr[1:0]!=0 gives resp_err=1, no write, rdata=0, same latency.
- Not defined: addr[1:0] is ignored and the access goes to the containing word.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/WAIT/RESP)
  - latency counter width constant (4)
  - default BASE_ADDR and DEPTH_LOG2 constants
- Sub-module ysyx_24070014_sram_array: single-port synchronous word array with per-byte write enable and registered read. The responder owns the FSM, counter, range check and response registers.

Test Plan:
- Write 0xDEADBEEF mask 4'hF to 0x80000010, then read 0x80000010 → write resp err=0 rdata=0; read resp rdata=0xDEADBEEF; each resp_valid exactly 2 cycles after accept.
- Write 0x000000AA mask 4'b0001 over 0x11223344 at 0x80000020, then read → 0x112233AA.
- Read 0x7FFFFFFC and 0x80004000 → err=1, rdata=0. Read 0x80003FFC → err=0.
- Hold resp_ready=0 for 5 cycles after a read → resp_valid, rdata and err stable; req_ready=0; a new req_valid is ignored until the handshake completes.
- reset=0 during WAIT of a write of 0x55 to 0x80000030 → after reset, resp_valid=0, req_ready=1; reading 0x80000030 returns the prior value.
- Macro defined: read 0x80000002 → err=1. Undefined: returns the word at 0x80000000.
